// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light safety slice.
// Holds the monitor state encodings, lamp bit positions within the 12-bit
// lamp vector {R1,Y1,G1,R2,Y2,G2,R3,Y3,G3,R4,Y4,G4}, the all-red pattern and
// the fault_code bit positions.
package traffic_pkg;

   typedef enum logic [1:0] {
      CLEAR_RED = 2'd0,
      PASS      = 2'd1,
      FLASH     = 2'd2
   } mon_state_e;

   localparam int unsigned R1_IDX = 11;
   localparam int unsigned Y1_IDX = 10;
   localparam int unsigned G1_IDX = 9;
   localparam int unsigned R2_IDX = 8;
   localparam int unsigned Y2_IDX = 7;
   localparam int unsigned G2_IDX = 6;
   localparam int unsigned R3_IDX = 5;
   localparam int unsigned Y3_IDX = 4;
   localparam int unsigned G3_IDX = 3;
   localparam int unsigned R4_IDX = 2;
   localparam int unsigned Y4_IDX = 1;
   localparam int unsigned G4_IDX = 0;

   localparam logic [11:0] ALL_RED = 12'b100_100_100_100;

   localparam int unsigned FC_ONEHOT_BIT   = 0;
   localparam int unsigned FC_CONFLICT_BIT = 1;

   // Fail-safe lamp image: every red follows the flash phase, Y/G dark.
   function automatic logic [11:0] flash_pattern(input logic phase);
      return phase ? ALL_RED : '0;
   endfunction

endpackage

// File: rtl/signal_conflict_monitor_if.sv
// Lamp bus between the light controller (master) and the conflict monitor
// (slave).
//   lamp_in    : commanded lamps from the controller
//   fault_clr  : operator clear request
//   lamp_out   : physical lamp drive from the monitor
//   fault      : latched fault flag
//   fault_code : {conflict, onehot_err} captured at fault confirmation
//   mon_state  : monitor state (0 CLEAR_RED, 1 PASS, 2 FLASH)
interface signal_conflict_monitor_if;

   logic [11:0] lamp_in;
   logic        fault_clr;
   logic [11:0] lamp_out;
   logic        fault;
   logic [1:0]  fault_code;
   logic [1:0]  mon_state;

   modport master (
      output lamp_in, fault_clr,
      input  lamp_out, fault, fault_code, mon_state
   );

   modport slave (
      input  lamp_in, fault_clr,
      output lamp_out, fault, fault_code, mon_state
   );

endinterface

// File: rtl/lamp_rule_check.sv
// Purely combinational legality check of a 12-bit lamp command.
//   lamp_in    : commanded lamps
//   onehot_err : some approach does not show exactly one of R/Y/G
//   conflict   : a movement on approaches 1/2 overlaps one on 3/4
//   viol       : onehot_err | conflict
module lamp_rule_check
   import traffic_pkg::*;
(
   input  logic [11:0] lamp_in,
   output logic        onehot_err,
   output logic        conflict,
   output logic        viol
);

   logic go_12;
   logic go_34;

   always_comb begin
      onehot_err = 1'b0;
      for (int unsigned a = 0; a < 4; a++) begin
         if ($countones(lamp_in[3*a +: 3]) != 1) begin
            onehot_err = 1'b1;
         end
      end
   end

   assign go_12 = lamp_in[Y1_IDX] | lamp_in[G1_IDX] | lamp_in[Y2_IDX] | lamp_in[G2_IDX];
   assign go_34 = lamp_in[Y3_IDX] | lamp_in[G3_IDX] | lamp_in[Y4_IDX] | lamp_in[G4_IDX];

   assign conflict = go_12 & go_34;
   assign viol     = onehot_err | conflict;

endmodule

// File: rtl/signal_conflict_monitor.sv
// Safety stage between the traffic light controller and the lamp drivers.
// Legal lamp commands pass through with one register of latency; a violation
// lasting FILT_CYCLES consecutive cycles latches a fault and forces
// flashing-red until an operator clear arrives with a legal command. Every
// start-up and recovery begins with ALL_RED_CYCLES of all-red clearance.
//   clk, reset : clock, asynchronous active-high reset
//   mon        : slave side of the lamp bus (see signal_conflict_monitor_if)
module signal_conflict_monitor
   import traffic_pkg::*;
#(
   parameter int unsigned FILT_CYCLES    = 2,
   parameter int unsigned FLASH_HALF     = 4,
   parameter int unsigned ALL_RED_CYCLES = 3
)(
   input  logic                     clk,
   input  logic                     reset,
   signal_conflict_monitor_if.slave mon
);

   localparam int unsigned VW = $clog2(FILT_CYCLES + 1);
   localparam int unsigned FW = $clog2(FLASH_HALF + 1);
   localparam int unsigned CW = $clog2(ALL_RED_CYCLES + 1);

   localparam logic [VW-1:0] VIOL_MAX   = VW'(FILT_CYCLES);
   localparam logic [VW-1:0] VIOL_LAST  = VW'(FILT_CYCLES - 1);
   localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);
   localparam logic [CW-1:0] CLR_LAST   = CW'(ALL_RED_CYCLES - 1);

   mon_state_e    state_q, state_d;
   logic [VW-1:0] viol_cnt_q, viol_cnt_d;
   logic [CW-1:0] clr_cnt_q, clr_cnt_d;
   logic [FW-1:0] flash_cnt_q, flash_cnt_d;
   logic          phase_q, phase_d;
   logic [11:0]   lamp_q, lamp_d;
   logic          fault_q, fault_d;
   logic [1:0]    code_q, code_d;

   logic onehot_err, conflict, viol, confirm;

   lamp_rule_check u_rule (
      .lamp_in    (mon.lamp_in),
      .onehot_err (onehot_err),
      .conflict   (conflict),
      .viol       (viol)
   );

   // viol_cnt counts earlier violating cycles, so the current one is the
   // FILT_CYCLES-th when the count has reached FILT_CYCLES-1.
   assign confirm = viol && (viol_cnt_q >= VIOL_LAST) && (state_q != FLASH);

   always_comb begin
      if (!viol) begin
         viol_cnt_d = '0;
      end else if (viol_cnt_q == VIOL_MAX) begin
         viol_cnt_d = viol_cnt_q;
      end else begin
         viol_cnt_d = viol_cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      flash_cnt_d = flash_cnt_q;
      phase_d     = phase_q;
      lamp_d      = lamp_q;
      fault_d     = fault_q;
      code_d      = code_q;

      case (state_q)
         CLEAR_RED: begin
            // Lamps stay all-red on the exit edge; pass-through starts next.
            lamp_d = ALL_RED;
            if (clr_cnt_q == CLR_LAST) begin
               state_d   = PASS;
               clr_cnt_d = '0;
               fault_d   = 1'b0;
               code_d    = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end
         PASS: begin
            if (!viol) begin
               lamp_d = mon.lamp_in;
            end
         end
         FLASH: begin
            if (mon.fault_clr && !viol) begin
               state_d   = CLEAR_RED;
               clr_cnt_d = '0;
               lamp_d    = ALL_RED;
            end else begin
               if (flash_cnt_q == FLASH_LAST) begin
                  flash_cnt_d = '0;
                  phase_d     = ~phase_q;
               end else begin
                  flash_cnt_d = flash_cnt_q + 1'b1;
               end
               lamp_d = flash_pattern(phase_d);
            end
         end
         default: begin
            state_d = CLEAR_RED;
            lamp_d  = ALL_RED;
         end
      endcase

      // Confirmation overrides both pass-through and clearance exit.
      if (confirm) begin
         state_d                 = FLASH;
         fault_d                 = 1'b1;
         code_d[FC_CONFLICT_BIT] = conflict;
         code_d[FC_ONEHOT_BIT]   = onehot_err;
         flash_cnt_d             = '0;
         phase_d                 = 1'b1;
         clr_cnt_d               = '0;
         lamp_d                  = flash_pattern(1'b1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= CLEAR_RED;
         viol_cnt_q  <= '0;
         clr_cnt_q   <= '0;
         flash_cnt_q <= '0;
         phase_q     <= 1'b1;
         lamp_q      <= ALL_RED;
         fault_q     <= 1'b0;
         code_q      <= '0;
      end else begin
         state_q     <= state_d;
         viol_cnt_q  <= viol_cnt_d;
         clr_cnt_q   <= clr_cnt_d;
         flash_cnt_q <= flash_cnt_d;
         phase_q     <= phase_d;
         lamp_q      <= lamp_d;
         fault_q     <= fault_d;
         code_q      <= code_d;
      end
   end

   assign mon.lamp_out   = lamp_q;
   assign mon.fault      = fault_q;
   assign mon.fault_code = code_q;
   assign mon.mon_state  = state_q;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Self-checking bench for signal_conflict_monitor: a behavioural model
// computes the expected outputs as each command is driven and pushes them to
// a scoreboard queue; they are popped and compared after the clock edge.
module tb_signal_conflict_monitor;

   localparam int unsigned FILT = 2;
   localparam int unsigned HALF = 4;
   localparam int unsigned ARED = 3;

   localparam logic [11:0] ALLR  = 12'b100100100100;
   localparam logic [11:0] LA    = 12'b001001100100;
   localparam logic [11:0] LB    = 12'b100100001001;
   localparam logic [11:0] LC    = 12'b010010100100;
   localparam logic [11:0] CONF  = 12'b001001001100;
   localparam logic [11:0] DARK1 = 12'b000001100100;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   signal_conflict_monitor_if mif ();

   signal_conflict_monitor #(
      .FILT_CYCLES    (FILT),
      .FLASH_HALF     (HALF),
      .ALL_RED_CYCLES (ARED)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .mon   (mif)
   );

   typedef struct packed {
      logic [11:0] lamp;
      logic        fault;
      logic [1:0]  code;
      logic [1:0]  st;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // model state: st 0 clear-red, 1 pass, 2 flash
   int          m_st, m_run, m_tclr, m_tfl;
   logic [11:0] m_lamp;
   logic        m_fault;
   logic [1:0]  m_code;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st    = 0;
      m_run   = 0;
      m_tclr  = 0;
      m_tfl   = 0;
      m_lamp  = ALLR;
      m_fault = 1'b0;
      m_code  = 2'b00;
   endtask

   task automatic step(input logic [11:0] l, input logic c);
      bit   oe, cf, v, confirm;
      int   ones;
      exp_t e;
      mif.lamp_in   = l;
      mif.fault_clr = c;
      oe = 1'b0;
      for (int a = 0; a < 4; a++) begin
         ones = int'(l[3*a]) + int'(l[3*a+1]) + int'(l[3*a+2]);
         if (ones != 1) oe = 1'b1;
      end
      cf = (l[10] | l[9] | l[7] | l[6]) & (l[4] | l[3] | l[1] | l[0]);
      v  = oe | cf;
      m_run   = v ? m_run + 1 : 0;
      confirm = v && (m_run >= FILT) && (m_st != 2);
      if (confirm) begin
         m_st    = 2;
         m_fault = 1'b1;
         m_code  = {cf, oe};
         m_tfl   = 0;
         m_tclr  = 0;
         m_lamp  = ALLR;
      end else begin
         case (m_st)
            0: begin
               m_lamp = ALLR;
               if (m_tclr == ARED - 1) begin
                  m_st    = 1;
                  m_fault = 1'b0;
                  m_code  = 2'b00;
               end else begin
                  m_tclr++;
               end
            end
            1: if (!v) m_lamp = l;
            default: begin
               if (c && !v) begin
                  m_st   = 0;
                  m_tclr = 0;
                  m_lamp = ALLR;
               end else begin
                  m_tfl++;
                  m_lamp = (((m_tfl / HALF) % 2) == 0) ? ALLR : 12'h000;
               end
            end
         endcase
      end
      sb.push_back('{lamp: m_lamp, fault: m_fault, code: m_code, st: 2'(m_st)});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("lamp_out",   32'(mif.lamp_out),   32'(e.lamp));
      check("fault",      32'(mif.fault),      32'(e.fault));
      check("fault_code", 32'(mif.fault_code), 32'(e.code));
      check("mon_state",  32'(mif.mon_state),  32'(e.st));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_lamp"},  32'(mif.lamp_out),   32'(ALLR));
      check({tag, "_state"}, 32'(mif.mon_state),  32'd0);
      check({tag, "_fault"}, 32'(mif.fault),      32'd0);
      check({tag, "_code"},  32'(mif.fault_code), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset         = 1'b1;
      mif.lamp_in   = LA;
      mif.fault_clr = 1'b0;
      #2;
      check_reset_values("reset");
      @(negedge clk);
      reset = 1'b0;
      model_reset();

      // start-up clearance, then pass-through of varied legal patterns
      repeat (4) step(LA, 1'b0);
      check("pass_state", 32'(mif.mon_state), 32'd1);
      check("pass_lamp",  32'(mif.lamp_out),  32'(LA));
      step(LB, 1'b0);
      step(LC, 1'b0);
      step(LA, 1'b0);
      step(LB, 1'b0);

      // single-cycle conflict glitch is filtered
      step(CONF, 1'b0);
      check("glitch_hold", 32'(mif.lamp_out), 32'(LB));
      step(LA, 1'b0);
      check("glitch_fault", 32'(mif.fault), 32'd0);

      // sustained conflict confirms a fault
      step(CONF, 1'b0);
      step(CONF, 1'b0);
      check("fc_conflict", 32'(mif.fault_code), 32'd2);
      check("flash_state", 32'(mif.mon_state),  32'd2);

      // clear during a violation is ignored
      step(CONF, 1'b1);
      check("clr_ignored", 32'(mif.mon_state), 32'd2);
      repeat (10) step(LA, 1'b0);

      // accepted clear: clearance, then pass with fault dropped
      step(LA, 1'b1);
      repeat (3) step(LA, 1'b0);
      check("recover_state", 32'(mif.mon_state), 32'd1);
      check("recover_fault", 32'(mif.fault),     32'd0);
      repeat (2) step(LC, 1'b0);

      // dark approach confirms a one-hot fault
      step(DARK1, 1'b0);
      step(DARK1, 1'b0);
      check("fc_onehot", 32'(mif.fault_code), 32'd1);
      repeat (3) step(LA, 1'b0);

      // asynchronous reset mid-flash
      #2 reset = 1'b1;
      #1 check_reset_values("midreset");
      #2 reset = 1'b0;
      model_reset();
      step(LA, 1'b0);

      // confirmation during clearance beats the exit
      step(CONF, 1'b0);
      step(CONF, 1'b0);
      check("clr_confirm_state", 32'(mif.mon_state), 32'd2);
      repeat (5) step(LA, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
